seq_lut_loader: RTL

Host-side programmer for the sequencer command LUT. It drives the LUT write/read port from the initiator end.
- Parks the sequencer in RST, accepts a command list over a valid/ready stream, and writes it at auto-incrementing LUT addresses.
- Reads the LUT back and compares it against an internal shadow copy.
- Releases the sequencer only after a clean verify.
- Sits between the register/host interface and sequencer_fsm.

---
 rtl/seq_lut_pkg.sv | 31 +++
 rtl/seq_lut_shadow.sv | 21 ++
 rtl/seq_lut_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seq_lut_pkg.sv
// seq_lut_pkg: LUT entry layout, sequencer state encodings and loader types shared
// by seq_lut_loader and sequencer_fsm.
package seq_lut_pkg;
  localparam int ENTRY_W   = 29;
  localparam int STATE_LSB = 0;
  localparam int STATE_W   = 3;
  localparam int RPT_W     = 8;
  localparam int LEN_W     = 16;
  localparam int EOF_BIT   = 27;
  localparam int SOF_BIT   = 28;

  typedef enum logic [STATE_W-1:0] {
    SEQ_RST, SEQ_IDLE, SEQ_ARM, SEQ_SETTLE, SEQ_EXPOSE, SEQ_SHIFT, SEQ_DUMP, SEQ_READOUT
  } seq_state_t;

  typedef struct packed {
    logic             sof;
    logic             eof;
    logic [LEN_W-1:0] data_length;
    logic [RPT_W-1:0] rpt;
    logic [STATE_W-1:0] state;
  } lut_entry_t;

  typedef enum logic [2:0] {
    ERR_NONE, ERR_BAD_STATE, ERR_NO_EOF, ERR_OVERFLOW, ERR_EARLY_EOF, ERR_NO_SOF, ERR_MISMATCH
  } err_code_t;

  typedef enum logic [2:0] {
    LD_IDLE, LD_CLR_W, LD_LOAD, LD_CLR_R, LD_VERIFY, LD_RELEASE, LD_DONE, LD_ERROR
  } ld_state_t;
endpackage

// File: rtl/seq_lut_shadow.sv
// seq_lut_shadow: loader's private copy of the written command list, used to
// verify the sequencer LUT on read-back.
module seq_lut_shadow #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = seq_lut_pkg::ENTRY_W,
  localparam int AW     = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/seq_lut_loader.sv
// seq_lut_loader: parks the sequencer, streams a command list into its LUT,
// reads it back against a shadow copy and releases the sequencer on a clean match.
module seq_lut_loader #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = seq_lut_pkg::ENTRY_W
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [ENTRY_W-1:0] cfg_data_i,
  input  logic               cfg_last_i,
  output logic               seq_hold_o,
  output logic               lut_addr_clr_o,
  output logic               lut_wen_o,
  output logic [ENTRY_W-1:0] lut_write_data_o,
  output logic               lut_rden_o,
  input  logic [ENTRY_W-1:0] lut_read_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [2:0]         err_code_o,
  output logic [7:0]         err_index_o,
  output logic [8:0]         entry_count_o
);
  import seq_lut_pkg::*;

  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

  ld_state_t          state_q, state_d;
  logic               wen_q, wen_d;
  logic [ENTRY_W-1:0] wdata_q, wdata_d;
  logic [8:0]         count_q, count_d, rd_q, rd_d;
  err_code_t          err_q, err_d, chk;
  logic [7:0]         eidx_q, eidx_d;
  logic [ENTRY_W-1:0] shadow_rd;
  logic [STATE_W-1:0] ent_state;
  logic               ent_sof, ent_eof;

  assign ent_state = cfg_data_i[STATE_LSB +: STATE_W];
  assign ent_sof   = cfg_data_i[SOF_BIT];
  assign ent_eof   = cfg_data_i[EOF_BIT];

  // Entry checks in priority order; count_q is the index of the entry on the bus.
  assign chk = (count_q == 9'd0 && !ent_sof)                 ? ERR_NO_SOF    :
               (ent_state < SEQ_ARM)                         ? ERR_BAD_STATE :
               (ent_eof && !cfg_last_i)                      ? ERR_EARLY_EOF :
               (cfg_last_i && !ent_eof)                      ? ERR_NO_EOF    :
               (!cfg_last_i && count_q == 9'(DEPTH - 1))     ? ERR_OVERFLOW  : ERR_NONE;

  always_comb begin
    state_d = state_q;
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    count_d = count_q;
    rd_d    = rd_q;
    err_d   = err_q;
    eidx_d  = eidx_q;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR:
        if (start_i) begin
          state_d = LD_CLR_W;
          count_d = '0;
          rd_d    = '0;
          err_d   = ERR_NONE;
          eidx_d  = '0;
        end
      LD_CLR_W: state_d = LD_LOAD;
      LD_LOAD:
        if (cfg_valid_i) begin
          if (chk != ERR_NONE) begin
            state_d = LD_ERROR;
            err_d   = chk;
            eidx_d  = count_q[7:0];
          end else begin
            wen_d   = 1'b1;
            wdata_d = cfg_data_i;
            count_d = count_q + 9'd1;
            state_d = cfg_last_i ? LD_CLR_R : LD_LOAD;
          end
        end
      // Hold off the address clear until the final write strobe has gone out.
      LD_CLR_R: state_d = wen_q ? LD_CLR_R : LD_VERIFY;
      LD_VERIFY:
        if (lut_read_data_i != shadow_rd) begin
          state_d = LD_ERROR;
          err_d   = ERR_MISMATCH;
          eidx_d  = rd_q[7:0];
        end else begin
          rd_d    = rd_q + 9'd1;
          state_d = (rd_q + 9'd1 == count_q) ? LD_RELEASE : LD_VERIFY;
        end
      LD_RELEASE: state_d = LD_DONE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i)
    if (reset_i) begin
      state_q <= LD_IDLE;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      count_q <= '0;
      rd_q    <= '0;
      err_q   <= ERR_NONE;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
    end

  seq_lut_shadow #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) u_shadow (
    .clk     (clk),
    .we_i    (wen_d),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (cfg_data_i),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (shadow_rd)
  );

  assign cfg_ready_o      = state_q == LD_LOAD;
  assign lut_wen_o        = wen_q;
  assign lut_write_data_o = wdata_q;
  assign lut_rden_o       = state_q == LD_VERIFY;
  assign lut_addr_clr_o   = state_q == LD_CLR_W || (state_q == LD_CLR_R && !wen_q);
  assign seq_hold_o       = !(state_q == LD_RELEASE || state_q == LD_DONE);
  assign busy_o           = !(state_q == LD_IDLE || state_q == LD_DONE || state_q == LD_ERROR);
  assign done_o           = state_q == LD_RELEASE;
  assign error_o          = state_q == LD_ERROR;
  assign err_code_o       = err_q;
  assign err_index_o      = eidx_q;
  assign entry_count_o    = count_q;
endmodule
